// File: rtl/multicycle_sequencer_if.sv
// Memory-side bus of the multicycle sequencer: req/ack access to unified memory.
// Latency: none, wires only.
// Backpressure: the requester holds mem_req and address/data until mem_ack.
interface multicycle_sequencer_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 16
);
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ack;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_rdata, mem_ack
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_rdata, mem_ack
  );
endinterface

// File: rtl/multicycle_sequencer.sv
// Multi-cycle CPU control sequencer: FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK with phase skipping.
// Latency: 3 cycles minimum per ALU-only instruction; memory phases add one cycle plus wait states.
// Backpressure: memory handshakes hold until mem_ack; stall freezes DECODE/EXECUTE/WRITEBACK only.
module multicycle_sequencer #(
  parameter int                DATA_W   = 16,
  parameter int                ADDR_W   = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(16'h0100),
  parameter int                CNT_W    = 32
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        stall,
  multicycle_sequencer_if.master      mem,
  output logic [DATA_W-1:0]           ir,
  output logic [ADDR_W-1:0]           pc,
  input  logic                        dec_mem,
  input  logic                        dec_store,
  input  logic                        dec_wb,
  input  logic                        dec_halt,
  input  logic                        dec_branch,
  input  logic [ADDR_W-1:0]           branch_target,
  input  logic [DATA_W-1:0]           alu_result,
  input  logic [DATA_W-1:0]           store_data,
  output logic                        rf_we,
  output logic [DATA_W-1:0]           rf_wdata,
  output logic [2:0]                  state,
  output logic                        halted,
  output logic [CNT_W-1:0]            retired
);

  typedef enum logic [2:0] {
    S_FETCH     = 3'd0,
    S_DECODE    = 3'd1,
    S_EXECUTE   = 3'd2,
    S_MEMORY    = 3'd3,
    S_WRITEBACK = 3'd4,
    S_HALT      = 3'd5
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [DATA_W-1:0] ir_q, ir_d;
  logic [DATA_W-1:0] result_q, result_d;
  logic [DATA_W-1:0] sdata_q, sdata_d;
  logic              mem_f_q, mem_f_d;
  logic              store_f_q, store_f_d;
  logic              wb_f_q, wb_f_d;
  logic              br_f_q, br_f_d;
  logic [ADDR_W-1:0] tgt_q, tgt_d;
  logic [CNT_W-1:0]  retired_q, retired_d;

  logic              req_c, we_c, rf_we_c, retire_c;
  logic [ADDR_W-1:0] addr_c;
  logic [DATA_W-1:0] wdata_c;

  // Next-state, datapath register updates and state-decoded outputs.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    ir_d      = ir_q;
    result_d  = result_q;
    sdata_d   = sdata_q;
    mem_f_d   = mem_f_q;
    store_f_d = store_f_q;
    wb_f_d    = wb_f_q;
    br_f_d    = br_f_q;
    tgt_d     = tgt_q;
    req_c     = 1'b0;
    we_c      = 1'b0;
    addr_c    = pc_q;
    wdata_c   = '0;
    rf_we_c   = 1'b0;
    retire_c  = 1'b0;

    case (state_q)
      S_FETCH: begin
        // stall is deliberately ignored so the bus handshake always completes
        req_c = 1'b1;
        if (mem.mem_ack) begin
          ir_d    = mem.mem_rdata;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        if (!stall) begin
          mem_f_d   = dec_mem;
          store_f_d = dec_store;
          wb_f_d    = dec_wb;
          br_f_d    = dec_branch;
          tgt_d     = branch_target;
          state_d   = dec_halt ? S_HALT : S_EXECUTE;
        end
      end
      S_EXECUTE: begin
        if (!stall) begin
          result_d = alu_result;
          sdata_d  = store_data;
          pc_d     = br_f_q ? tgt_q : pc_q + ADDR_W'(1);
          if (mem_f_q) begin
            state_d = S_MEMORY;
          end else if (wb_f_q) begin
            state_d = S_WRITEBACK;
          end else begin
            state_d  = S_FETCH;
            retire_c = 1'b1;
          end
        end
      end
      S_MEMORY: begin
        req_c   = 1'b1;
        we_c    = store_f_q;
        addr_c  = result_q[ADDR_W-1:0];
        wdata_c = sdata_q;
        if (mem.mem_ack) begin
          if (!store_f_q) begin
            result_d = mem.mem_rdata;
          end
          if (wb_f_q) begin
            state_d = S_WRITEBACK;
          end else begin
            state_d  = S_FETCH;
            retire_c = 1'b1;
          end
        end
      end
      S_WRITEBACK: begin
        if (!stall) begin
          rf_we_c  = 1'b1;
          state_d  = S_FETCH;
          retire_c = 1'b1;
        end
      end
      S_HALT: begin
        state_d = S_HALT;
      end
      default: begin
        state_d = S_FETCH;
      end
    endcase

    retired_d = retire_c ? retired_q + CNT_W'(1) : retired_q;
  end

  // Sequencer state and datapath registers; reset abandons any access in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_FETCH;
      pc_q      <= RESET_PC;
      ir_q      <= '0;
      result_q  <= '0;
      sdata_q   <= '0;
      mem_f_q   <= 1'b0;
      store_f_q <= 1'b0;
      wb_f_q    <= 1'b0;
      br_f_q    <= 1'b0;
      tgt_q     <= '0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      ir_q      <= ir_d;
      result_q  <= result_d;
      sdata_q   <= sdata_d;
      mem_f_q   <= mem_f_d;
      store_f_q <= store_f_d;
      wb_f_q    <= wb_f_d;
      br_f_q    <= br_f_d;
      tgt_q     <= tgt_d;
      retired_q <= retired_d;
    end
  end

  // Requests and register writes are suppressed while reset is held.
  assign mem.mem_req   = req_c & ~rst;
  assign mem.mem_we    = we_c & ~rst;
  assign mem.mem_addr  = addr_c;
  assign mem.mem_wdata = wdata_c;
  assign rf_we         = rf_we_c & ~rst;
  assign rf_wdata      = result_q;
  assign ir            = ir_q;
  assign pc            = pc_q;
  assign state         = state_q;
  assign halted        = (state_q == S_HALT);
  assign retired       = retired_q;

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Self-checking bench for multicycle_sequencer: scoreboarded memory accesses and register writes.
// Latency: bench drives inputs #1 after the rising edge, samples on the falling edge.
// Backpressure: memory wait states and stall are driven from the stimulus tasks.
module tb_multicycle_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic [15:0] ir, pc;
  logic        dec_mem, dec_store, dec_wb, dec_halt, dec_branch;
  logic [15:0] branch_target, alu_result, store_data;
  logic        rf_we;
  logic [15:0] rf_wdata;
  logic [2:0]  state;
  logic        halted;
  logic [31:0] retired;

  multicycle_sequencer_if #(.DATA_W(16), .ADDR_W(16)) mem_if ();

  multicycle_sequencer dut (
    .clk(clk), .rst(rst), .stall(stall), .mem(mem_if.master),
    .ir(ir), .pc(pc),
    .dec_mem(dec_mem), .dec_store(dec_store), .dec_wb(dec_wb),
    .dec_halt(dec_halt), .dec_branch(dec_branch),
    .branch_target(branch_target), .alu_result(alu_result), .store_data(store_data),
    .rf_we(rf_we), .rf_wdata(rf_wdata), .state(state), .halted(halted), .retired(retired)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] instr;
    int          fwait;
    bit          fstall;
    bit          m, st, wb, halt, br;
    logic [15:0] tgt, alu, sd;
    int          mwait;
    logic [15:0] mrd;
    int          wbstall;
  } ins_t;

  int total = 0;
  int bad   = 0;
  int rf_cnt = 0;
  logic [15:0] pc_m;
  int          ret_m;
  logic [32:0] exp_mem[$];   // {we, addr, wdata}
  logic [15:0] exp_rf[$];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  function automatic ins_t blank();
    ins_t i;
    i.instr = '0; i.fwait = 0; i.fstall = 0;
    i.m = 0; i.st = 0; i.wb = 0; i.halt = 0; i.br = 0;
    i.tgt = '0; i.alu = '0; i.sd = '0;
    i.mwait = 0; i.mrd = '0; i.wbstall = 0;
    return i;
  endfunction

  // Monitor: pops scoreboard entries whenever the DUT completes an access or writes a register.
  always @(negedge clk) begin
    if (!rst) begin
      if (mem_if.mem_req && mem_if.mem_ack) begin
        if (exp_mem.size() == 0) begin
          chk("mem_unexpected", 1, 0);
        end else begin
          logic [32:0] e;
          e = exp_mem.pop_front();
          chk("mem_we", mem_if.mem_we, e[32]);
          chk("mem_addr", mem_if.mem_addr, e[31:16]);
          chk("mem_wdata", mem_if.mem_wdata, e[15:0]);
        end
      end
      if (!mem_if.mem_req) chk("idle_wdata", mem_if.mem_wdata, 16'h0);
      if (rf_we) begin
        rf_cnt++;
        if (exp_rf.size() == 0) chk("rf_unexpected", 1, 0);
        else chk("rf_wdata", rf_wdata, exp_rf.pop_front());
      end
    end
  end

  // Waits (bounded) for a request, inserts wait states, then acks for one cycle.
  task automatic mem_cycle(input int waits, input logic [15:0] rdata);
    for (int k = 0; k < 30 && !mem_if.mem_req; k++) begin
      @(posedge clk); #1;
    end
    if (!mem_if.mem_req) chk("req_timeout", 0, 1);
    repeat (waits) begin
      @(posedge clk); #1;
    end
    mem_if.mem_ack   = 1'b1;
    mem_if.mem_rdata = rdata;
    @(posedge clk); #1;
    mem_if.mem_ack   = 1'b0;
    mem_if.mem_rdata = 16'hA5A5;
  endtask

  task automatic run_instr(input ins_t i);
    logic [15:0] res;
    int rf_before;
    exp_mem.push_back({1'b0, pc_m, 16'h0});
    stall = i.fstall;
    mem_cycle(i.fwait, i.instr);
    stall = 1'b0;
    chk("st_decode", state, 3'd1);
    chk("ir", ir, i.instr);
    dec_mem = i.m; dec_store = i.st; dec_wb = i.wb; dec_halt = i.halt; dec_branch = i.br;
    branch_target = i.tgt; alu_result = i.alu; store_data = i.sd;
    @(posedge clk); #1;
    dec_mem = 0; dec_store = 0; dec_wb = 0; dec_halt = 0; dec_branch = 0;
    branch_target = 16'h0BAD;
    if (i.halt) begin
      chk("st_halt", state, 3'd5);
      return;
    end
    chk("st_execute", state, 3'd2);
    pc_m = i.br ? i.tgt : pc_m + 16'd1;
    @(posedge clk); #1;
    alu_result = 16'hDEAD; store_data = 16'hDEAD;
    res = i.alu;
    if (i.m) begin
      chk("st_memory", state, 3'd3);
      exp_mem.push_back({i.st, i.alu, i.sd});
      mem_cycle(i.mwait, i.mrd);
      if (!i.st) res = i.mrd;
    end
    if (i.wb) begin
      chk("st_writeback", state, 3'd4);
      exp_rf.push_back(res);
      rf_before = rf_cnt;
      stall = (i.wbstall > 0);
      repeat (i.wbstall) begin
        @(negedge clk);
        chk("stall_rf_we", rf_we, 1'b0);
        chk("stall_state", state, 3'd4);
        @(posedge clk); #1;
      end
      stall = 1'b0;
      @(posedge clk); #1;
      chk("rf_pulses", rf_cnt, rf_before + 1);
    end
    ret_m++;
    chk("st_fetch", state, 3'd0);
    chk("pc", pc, pc_m);
    chk("retired", retired, ret_m);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    ins_t i;
    rst = 1'b1; stall = 1'b0;
    dec_mem = 0; dec_store = 0; dec_wb = 0; dec_halt = 0; dec_branch = 0;
    branch_target = '0; alu_result = '0; store_data = '0;
    mem_if.mem_ack = 1'b0; mem_if.mem_rdata = '0;
    pc_m = 16'h0100; ret_m = 0;

    #12;
    chk("rst_req", mem_if.mem_req, 1'b0);
    chk("rst_state", state, 3'd0);
    chk("rst_pc", pc, 16'h0100);
    chk("rst_ir", ir, 16'h0);
    chk("rst_retired", retired, 0);
    chk("rst_halted", halted, 1'b0);
    @(posedge clk); #1 rst = 1'b0;
    #1;
    chk("fetch_req", mem_if.mem_req, 1'b1);
    chk("fetch_addr", mem_if.mem_addr, 16'h0100);

    // ALU-only instruction, zero-wait fetch
    i = blank(); i.instr = 16'h1234; i.alu = 16'h0042;
    run_instr(i);
    // load with 3 memory wait states and writeback
    i = blank(); i.instr = 16'h2000; i.fwait = 1; i.m = 1; i.wb = 1;
    i.alu = 16'h0200; i.mwait = 3; i.mrd = 16'hBEEF;
    run_instr(i);
    // taken branch to the top of the address space
    i = blank(); i.instr = 16'h3000; i.br = 1; i.tgt = 16'hFFFF;
    run_instr(i);
    // store at pc 0xFFFF, branch not taken: pc wraps to 0
    i = blank(); i.instr = 16'h4000; i.m = 1; i.st = 1; i.alu = 16'h0300;
    i.sd = 16'h55AA; i.mwait = 1; i.mrd = 16'h1111; i.tgt = 16'h7777;
    run_instr(i);
    // stall held through fetch, then 4 stalled writeback cycles on a load
    i = blank(); i.instr = 16'h5000; i.fstall = 1; i.fwait = 2; i.m = 1; i.wb = 1;
    i.alu = 16'h0010; i.mrd = 16'h0A5A; i.wbstall = 4;
    run_instr(i);
    // ALU result written back without a memory phase
    i = blank(); i.instr = 16'h6000; i.wb = 1; i.alu = 16'h7777;
    run_instr(i);

    // halt: no requests, counter frozen
    i = blank(); i.instr = 16'hF000; i.halt = 1;
    run_instr(i);
    mem_if.mem_ack = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      chk("halt_idle", {state, halted, mem_if.mem_req}, {3'd5, 1'b1, 1'b0});
    end
    mem_if.mem_ack = 1'b0;
    chk("halt_retired", retired, ret_m);

    @(posedge clk); #1 rst = 1'b1;
    #1 chk("rst_unhalt", halted, 1'b0);
    @(posedge clk); #1 rst = 1'b0;
    pc_m = 16'h0100; ret_m = 0;
    i = blank(); i.instr = 16'h4321;
    run_instr(i);

    // reset in the middle of a memory access
    exp_mem.push_back({1'b0, pc_m, 16'h0});
    mem_cycle(0, 16'h9999);
    dec_mem = 1; dec_wb = 1; alu_result = 16'h0400;
    @(posedge clk); #1;
    dec_mem = 0; dec_wb = 0;
    @(posedge clk); #1;
    chk("mid_state", state, 3'd3);
    chk("mid_req", mem_if.mem_req, 1'b1);
    chk("mid_addr", mem_if.mem_addr, 16'h0400);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_req", mem_if.mem_req, 1'b0);
    chk("mid_rst_state", state, 3'd0);
    mem_if.mem_ack = 1'b1; mem_if.mem_rdata = 16'hBAD0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    mem_if.mem_ack = 1'b0;
    rst = 1'b0;
    #1;
    chk("post_rst_req", mem_if.mem_req, 1'b1);
    chk("post_rst_addr", mem_if.mem_addr, 16'h0100);
    chk("post_rst_ir", ir, 16'h0);
    chk("post_rst_retired", retired, 0);
    pc_m = 16'h0100; ret_m = 0;
    i = blank(); i.instr = 16'h0F0F;
    run_instr(i);

    chk("sb_drained", exp_mem.size() + exp_rf.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
